// File: rtl/arm_uop_pkg.sv
// Micro-op codes, condition codes and the decoded-bundle type shared by
// Thumb Decode and Execute.
package arm_uop_pkg;

    localparam logic [4:0] UOP_NOP = 5'd0;
    localparam logic [4:0] UOP_ADD = 5'd1;
    localparam logic [4:0] UOP_SUB = 5'd2;
    localparam logic [4:0] UOP_AND = 5'd3;
    localparam logic [4:0] UOP_ORR = 5'd4;
    localparam logic [4:0] UOP_CMP = 5'd5;
    localparam logic [4:0] UOP_EOR = 5'd6;
    localparam logic [4:0] UOP_MVN = 5'd7;
    localparam logic [4:0] UOP_MOV = 5'd8;
    localparam logic [4:0] UOP_B   = 5'd11;
    localparam logic [4:0] UOP_BL  = 5'd12;

    localparam logic [3:0] COND_AL   = 4'b1110;
    localparam logic [3:0] COND_NONE = 4'b1111;
    localparam logic [3:0] LR_IDX    = 4'd14;

    typedef struct packed {
        logic        num_to_rhs;
        logic [31:0] num;
        logic [3:0]  sel_p0;
        logic [3:0]  sel_p1;
        logic [3:0]  sel_in;
        logic [4:0]  uop;
        logic [3:0]  branch_cond;
    } uop_bundle_t;

    // Classification of a halfword; PREFIX/SUFFIX are the two halves of BL.
    typedef enum logic [1:0] {
        DEC_OK,
        DEC_UNDEF,
        DEC_PREFIX,
        DEC_SUFFIX
    } dec_kind_e;

    localparam uop_bundle_t NOP_BUNDLE = '{
        num_to_rhs:  1'b0,
        num:         32'd0,
        sel_p0:      4'd0,
        sel_p1:      4'd0,
        sel_in:      4'd0,
        uop:         UOP_NOP,
        branch_cond: COND_NONE
    };

    function automatic logic [31:0] sext8_x2(input logic [7:0] v);
        return {{23{v[7]}}, v, 1'b0};
    endfunction

    function automatic logic [31:0] sext11_x2(input logic [10:0] v);
        return {{20{v[10]}}, v, 1'b0};
    endfunction

endpackage

// File: rtl/thumb_decode_comb.sv
// Purely combinational Thumb field decode: turns one halfword into a
// micro-op bundle plus a classification (ok / undefined / BL prefix / BL suffix).
module thumb_decode_comb
    import arm_uop_pkg::*;
(
    input  logic [15:0] instr,
    output uop_bundle_t dec,
    output dec_kind_e   kind
);

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        dec  = NOP_BUNDLE;
        kind = DEC_UNDEF;

        if (instr[15:11] == 5'b00100) begin
            dec.uop        = UOP_MOV;
            dec.num_to_rhs = 1'b1;
            dec.num        = {24'd0, instr[7:0]};
            dec.sel_in     = {1'b0, instr[10:8]};
            kind           = DEC_OK;
        end else if (instr[15:11] == 5'b00101) begin
            dec.uop        = UOP_CMP;
            dec.num_to_rhs = 1'b1;
            dec.num        = {24'd0, instr[7:0]};
            dec.sel_p0     = {1'b0, instr[10:8]};
            kind           = DEC_OK;
        end else if (instr[15:10] == 6'b000110) begin
            dec.uop    = instr[9] ? UOP_SUB : UOP_ADD;
            dec.sel_p0 = {1'b0, instr[5:3]};
            dec.sel_p1 = {1'b0, instr[8:6]};
            dec.sel_in = {1'b0, instr[2:0]};
            kind       = DEC_OK;
        end else if (instr[15:9] == 7'b0001110) begin
            dec.uop        = UOP_ADD;
            dec.num_to_rhs = 1'b1;
            dec.num        = {29'd0, instr[8:6]};
            dec.sel_p0     = {1'b0, instr[5:3]};
            dec.sel_in     = {1'b0, instr[2:0]};
            kind           = DEC_OK;
        end else if (instr[15:10] == 6'b010000) begin
            dec.sel_p0 = {1'b0, instr[2:0]};
            dec.sel_p1 = {1'b0, instr[5:3]};
            dec.sel_in = {1'b0, instr[2:0]};
            kind       = DEC_OK;
            case (instr[9:6])
                4'b0000: dec.uop = UOP_AND;
                4'b0001: dec.uop = UOP_EOR;
                4'b1010: dec.uop = UOP_CMP;
                4'b1100: dec.uop = UOP_ORR;
                4'b1111: dec.uop = UOP_MVN;
                default: begin
                    dec  = NOP_BUNDLE;
                    kind = DEC_UNDEF;
                end
            endcase
        end else if (instr[15:8] == 8'b01000110) begin
            dec.uop    = UOP_MOV;
            dec.sel_p0 = instr[6:3];
            dec.sel_in = {instr[7], instr[2:0]};
            kind       = DEC_OK;
        end else if (instr[15:12] == 4'b1101 && instr[11:9] != 3'b111) begin
            // Conditions 1110/1111 in this slot are not conditional branches.
            dec.uop         = UOP_B;
            dec.branch_cond = instr[11:8];
            dec.num         = sext8_x2(instr[7:0]);
            kind            = DEC_OK;
        end else if (instr[15:11] == 5'b11100) begin
            dec.uop         = UOP_B;
            dec.branch_cond = COND_AL;
            dec.num         = sext11_x2(instr[10:0]);
            kind            = DEC_OK;
        end else if (instr[15:11] == 5'b11110) begin
            kind = DEC_PREFIX;
        end else if (instr[15:11] == 5'b11111) begin
            kind = DEC_SUFFIX;
        end
    end

endmodule

// File: rtl/thumb_decode.sv
// Thumb decode stage: registers the decoded bundle with 1-cycle latency.
// Define THUMB_BL_EN to build the two-halfword BL prefix/suffix state machine.
module thumb_decode
    import arm_uop_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] instr,
    input  logic        in_valid,
    input  logic        global_disable,
    output logic        num_to_rhs,
    output logic [31:0] num,
    output logic [3:0]  sel_p0,
    output logic [3:0]  sel_p1,
    output logic [3:0]  sel_in,
    output logic [4:0]  uop,
    output logic [3:0]  branch_cond,
    output logic        out_valid,
    output logic        undef
);

    uop_bundle_t dec;
    dec_kind_e   kind;

    uop_bundle_t out_d, out_q;
    logic        out_valid_d, out_valid_q;
    logic        undef_d, undef_q;

    thumb_decode_comb u_comb (
        .instr (instr),
        .dec   (dec),
        .kind  (kind)
    );

`ifdef THUMB_BL_EN
    typedef enum logic {
        BL_IDLE,
        BL_HAVE_PREFIX
    } bl_state_e;

    bl_state_e   state_d, state_q;
    logic [10:0] hi_d, hi_q;
`endif

    always_comb begin
        out_d       = NOP_BUNDLE;
        out_valid_d = 1'b0;
        undef_d     = 1'b0;
`ifdef THUMB_BL_EN
        state_d     = state_q;
        hi_d        = hi_q;
`endif
        if (global_disable) begin
`ifdef THUMB_BL_EN
            state_d = BL_IDLE;
`endif
        end else if (in_valid) begin
`ifdef THUMB_BL_EN
            // Anything other than a fresh prefix ends a pending pair.
            state_d = BL_IDLE;
            case (kind)
                DEC_OK: begin
                    out_d       = dec;
                    out_valid_d = 1'b1;
                end
                DEC_PREFIX: begin
                    state_d = BL_HAVE_PREFIX;
                    hi_d    = instr[10:0];
                end
                DEC_SUFFIX: begin
                    if (state_q == BL_HAVE_PREFIX) begin
                        out_d.uop         = UOP_BL;
                        out_d.num         = {{9{hi_q[10]}}, hi_q, instr[10:0], 1'b0};
                        out_d.sel_in      = LR_IDX;
                        out_d.branch_cond = COND_AL;
                        out_valid_d       = 1'b1;
                    end else begin
                        undef_d = 1'b1;
                    end
                end
                default: undef_d = 1'b1;
            endcase
`else
            if (kind == DEC_OK) begin
                out_d       = dec;
                out_valid_d = 1'b1;
            end else begin
                undef_d = 1'b1;
            end
`endif
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q       <= NOP_BUNDLE;
            out_valid_q <= 1'b0;
            undef_q     <= 1'b0;
        end else begin
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            undef_q     <= undef_d;
        end
    end

`ifdef THUMB_BL_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BL_IDLE;
            hi_q    <= 11'd0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
        end
    end
`endif

    assign num_to_rhs  = out_q.num_to_rhs;
    assign num         = out_q.num;
    assign sel_p0      = out_q.sel_p0;
    assign sel_p1      = out_q.sel_p1;
    assign sel_in      = out_q.sel_in;
    assign uop         = out_q.uop;
    assign branch_cond = out_q.branch_cond;
    assign out_valid   = out_valid_q;
    assign undef       = undef_q;

endmodule

// File: tb/tb_thumb_decode.sv
// Directed, table-driven bench for thumb_decode; BL expectations follow
// whether THUMB_BL_EN is defined for the build.
module tb_thumb_decode;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] instr;
    logic        in_valid;
    logic        global_disable;
    logic        num_to_rhs;
    logic [31:0] num;
    logic [3:0]  sel_p0, sel_p1, sel_in, branch_cond;
    logic [4:0]  uop;
    logic        out_valid;
    logic        undef;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    thumb_decode dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .instr          (instr),
        .in_valid       (in_valid),
        .global_disable (global_disable),
        .num_to_rhs     (num_to_rhs),
        .num            (num),
        .sel_p0         (sel_p0),
        .sel_p1         (sel_p1),
        .sel_in         (sel_in),
        .uop            (uop),
        .branch_cond    (branch_cond),
        .out_valid      (out_valid),
        .undef          (undef)
    );

    typedef struct packed {
        logic [4:0]  uop;
        logic        ntr;
        logic [31:0] num;
        logic [3:0]  p0;
        logic [3:0]  p1;
        logic [3:0]  in;
        logic [3:0]  cond;
        logic        valid;
        logic        undef;
    } exp_t;

    typedef struct packed {
        logic [15:0] instr;
        logic        in_valid;
        logic        gdis;
        exp_t        e;
    } vec_t;

    localparam int NVEC = 20;
    vec_t vecs [NVEC];

    localparam exp_t NOP_E   = '{5'd0, 1'b0, 32'd0, 4'd0, 4'd0, 4'd0, 4'hF, 1'b0, 1'b0};
    localparam exp_t UNDEF_E = '{5'd0, 1'b0, 32'd0, 4'd0, 4'd0, 4'd0, 4'hF, 1'b0, 1'b1};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_out(input string tag, input exp_t e);
        check({tag, ".uop"},   32'(uop),         32'(e.uop));
        check({tag, ".ntr"},   32'(num_to_rhs),  32'(e.ntr));
        check({tag, ".num"},   num,              e.num);
        check({tag, ".p0"},    32'(sel_p0),      32'(e.p0));
        check({tag, ".p1"},    32'(sel_p1),      32'(e.p1));
        check({tag, ".in"},    32'(sel_in),      32'(e.in));
        check({tag, ".cond"},  32'(branch_cond), 32'(e.cond));
        check({tag, ".valid"}, 32'(out_valid),   32'(e.valid));
        check({tag, ".undef"}, 32'(undef),       32'(e.undef));
    endtask

    // Present one halfword for one edge, then sample 1 ns after the edge.
    task automatic step(input logic [15:0] i, input logic v, input logic g);
        instr          = i;
        in_valid       = v;
        global_disable = g;
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t bl_e(input logic [31:0] n);
        return '{5'd12, 1'b0, n, 4'd0, 4'd0, 4'd14, 4'hE, 1'b1, 1'b0};
    endfunction

    function automatic exp_t mov_2155_e();
        return '{5'd8, 1'b1, 32'h55, 4'd0, 4'd0, 4'd1, 4'hF, 1'b1, 1'b0};
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //            instr     v     g     uop    ntr   num            p0    p1    in    cond  val   und
        vecs[0]  = '{16'h2155, 1'b1, 1'b0, mov_2155_e()};
        vecs[1]  = '{16'h1888, 1'b1, 1'b0, '{5'd1,  1'b0, 32'h0,        4'd1, 4'd2, 4'd0, 4'hF, 1'b1, 1'b0}};
        vecs[2]  = '{16'hD0FE, 1'b1, 1'b0, '{5'd11, 1'b0, 32'hFFFFFFFC, 4'd0, 4'd0, 4'd0, 4'h0, 1'b1, 1'b0}};
        vecs[3]  = '{16'h2155, 1'b1, 1'b1, NOP_E};
        vecs[4]  = '{16'h2A7F, 1'b1, 1'b0, '{5'd5,  1'b1, 32'h7F,       4'd2, 4'd0, 4'd0, 4'hF, 1'b1, 1'b0}};
        vecs[5]  = '{16'h1C4B, 1'b1, 1'b0, '{5'd1,  1'b1, 32'h1,        4'd1, 4'd0, 4'd3, 4'hF, 1'b1, 1'b0}};
        vecs[6]  = '{16'h1A8A, 1'b1, 1'b0, '{5'd2,  1'b0, 32'h0,        4'd1, 4'd2, 4'd2, 4'hF, 1'b1, 1'b0}};
        vecs[7]  = '{16'h405D, 1'b1, 1'b0, '{5'd6,  1'b0, 32'h0,        4'd5, 4'd3, 4'd5, 4'hF, 1'b1, 1'b0}};
        vecs[8]  = '{16'h43CA, 1'b1, 1'b0, '{5'd7,  1'b0, 32'h0,        4'd2, 4'd1, 4'd2, 4'hF, 1'b1, 1'b0}};
        vecs[9]  = '{16'h4307, 1'b1, 1'b0, '{5'd4,  1'b0, 32'h0,        4'd7, 4'd0, 4'd7, 4'hF, 1'b1, 1'b0}};
        vecs[10] = '{16'h4038, 1'b1, 1'b0, '{5'd3,  1'b0, 32'h0,        4'd0, 4'd7, 4'd0, 4'hF, 1'b1, 1'b0}};
        vecs[11] = '{16'h4291, 1'b1, 1'b0, '{5'd5,  1'b0, 32'h0,        4'd1, 4'd2, 4'd1, 4'hF, 1'b1, 1'b0}};
        vecs[12] = '{16'h4080, 1'b1, 1'b0, UNDEF_E};
        vecs[13] = '{16'h46D3, 1'b1, 1'b0, '{5'd8,  1'b0, 32'h0,        4'hA, 4'd0, 4'hB, 4'hF, 1'b1, 1'b0}};
        vecs[14] = '{16'hE7FF, 1'b1, 1'b0, '{5'd11, 1'b0, 32'hFFFFFFFE, 4'd0, 4'd0, 4'd0, 4'hE, 1'b1, 1'b0}};
        vecs[15] = '{16'hDA10, 1'b1, 1'b0, '{5'd11, 1'b0, 32'h20,       4'd0, 4'd0, 4'd0, 4'hA, 1'b1, 1'b0}};
        vecs[16] = '{16'hDE00, 1'b1, 1'b0, UNDEF_E};
        vecs[17] = '{16'h2155, 1'b0, 1'b0, NOP_E};
        vecs[18] = '{16'hF802, 1'b1, 1'b0, UNDEF_E};
        vecs[19] = '{16'h0000, 1'b1, 1'b0, UNDEF_E};

        rst_n          = 1'b0;
        instr          = 16'h2155;
        in_valid       = 1'b1;
        global_disable = 1'b0;
        @(posedge clk);
        #1;
        check_out("reset", NOP_E);
        @(negedge clk);
        rst_n = 1'b1;

        for (int k = 0; k < NVEC; k++) begin
            step(vecs[k].instr, vecs[k].in_valid, vecs[k].gdis);
            check_out($sformatf("vec%0d", k), vecs[k].e);
        end

        // Prefix followed by suffix.
        step(16'hF000, 1'b1, 1'b0);
`ifdef THUMB_BL_EN
        check_out("bl.prefix", NOP_E);
        step(16'hF802, 1'b1, 1'b0);
        check_out("bl.suffix", bl_e(32'h4));
`else
        check_out("bl.prefix", UNDEF_E);
        step(16'hF802, 1'b1, 1'b0);
        check_out("bl.suffix", UNDEF_E);
`endif

        // A second prefix replaces the stored high half.
        step(16'hF7FF, 1'b1, 1'b0);
        step(16'hF001, 1'b1, 1'b0);
        step(16'hF800, 1'b1, 1'b0);
`ifdef THUMB_BL_EN
        check_out("bl.overwrite", bl_e(32'h1000));
`else
        check_out("bl.overwrite", UNDEF_E);
`endif

        // A non-BL halfword between the halves drops the prefix.
        step(16'hF000, 1'b1, 1'b0);
        step(16'h2155, 1'b1, 1'b0);
        check_out("bl.drop.mid", mov_2155_e());
        step(16'hF802, 1'b1, 1'b0);
        check_out("bl.drop.sfx", UNDEF_E);

        // A flush between the halves drops the prefix.
        step(16'hF000, 1'b1, 1'b0);
        step(16'hF802, 1'b1, 1'b1);
        check_out("bl.flush.mid", NOP_E);
        step(16'hF802, 1'b1, 1'b0);
        check_out("bl.flush.sfx", UNDEF_E);

        // Reset between the halves discards the prefix.
        step(16'hF000, 1'b1, 1'b0);
        instr    = 16'h0000;
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #2;
        check_out("bl.rst.during", NOP_E);
        @(negedge clk);
        rst_n = 1'b1;
        step(16'hF802, 1'b1, 1'b0);
        check_out("bl.rst.sfx", UNDEF_E);

        // undef lasts a single cycle.
        step(16'h2155, 1'b0, 1'b0);
        check_out("undef.clear", NOP_E);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
